// File: rtl/tl_pkg.sv
// Shared TLP definitions for the TL transmit path: header layout, format bit
// positions and header/length decode helpers.
package tl_pkg;

  localparam int FMT_HAS_DATA = 30;
  localparam int FMT_4DW      = 29;

  typedef struct packed {
    logic [31:0] dw3;
    logic [31:0] dw2;
    logic [31:0] dw1;
    logic [31:0] dw0;
  } tlp_hdr_t;

  // A zero length field encodes the maximum of 1024 DWs.
  function automatic logic [10:0] tlp_len_dw(input logic [31:0] dw0);
    return (dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0[9:0]};
  endfunction

  function automatic logic [2:0] hdr_dws(input logic [31:0] dw0);
    return dw0[FMT_4DW] ? 3'd4 : 3'd3;
  endfunction

  function automatic logic [5:0] keep_count(input logic [31:0] keep);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(keep[i]);
    return n;
  endfunction

endpackage

// File: rtl/tl_commit_fifo.sv
// DW payload FIFO with a multi-DW write port and speculative/commit pointers,
// so a partially received TLP can be rewound without egress ever seeing it.
module tl_commit_fifo
  import tl_pkg::*;
#(
  parameter int KW    = 4,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [KW*32-1:0] wr_data,
  input  logic [KW-1:0]    wr_keep,
  input  logic             commit,
  input  logic             rewind,
  input  logic             rd_en,
  output logic [31:0]      rd_data,
  output logic [PW-1:0]    free
);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_spec;
  logic [PW-1:0] wr_cmt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_cnt;
  logic [PW-1:0] wr_spec_next;

  assign wr_cnt       = wr_en ? PW'(keep_count(32'(wr_keep))) : '0;
  assign wr_spec_next = wr_spec + wr_cnt;

  // NOTE: the storage array has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < KW; i++) begin
        if (wr_keep[i]) mem[AW'(wr_spec + PW'(i))] <= wr_data[i*32 +: 32];
      end
    end
  end

  // NOTE: non-blocking assignments so every pointer update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_spec <= '0;
      wr_cmt  <= '0;
      rd_ptr  <= '0;
    end else begin
      wr_spec <= rewind ? wr_cmt : wr_spec_next;
      if (commit) wr_cmt <= wr_spec_next;
      if (rd_en)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign free    = PW'(DEPTH) - (wr_spec - rd_ptr);

endmodule

// File: rtl/tl_tx_tlp_framer.sv
// Store-and-forward TLP framer: AXI-stream TLPs from DMA in, 32-bit DW link
// stream out, with length checking and drop-on-error.
module tl_tx_tlp_framer
  import tl_pkg::*;
#(
  parameter int DATA_W         = 128,
  parameter int FIFO_DEPTH     = 256,
  parameter int HDR_DEPTH      = 4,
  parameter int MAX_PAYLOAD_DW = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  input  logic [127:0]        s_tuser,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/32-1:0] s_tkeep,
  output logic [31:0]         m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tsop,
  output logic                m_teop,
  output logic                err_len,
  output logic [15:0]         err_count,
  output logic [15:0]         tlp_count
);

  localparam int KW  = DATA_W / 32;
  localparam int PW  = $clog2(FIFO_DEPTH) + 1;
  localparam int HQW = $clog2(HDR_DEPTH);
  localparam logic [PW-1:0] KW_FREE = PW'(KW);
  localparam logic [10:0]   MAX_DW  = 11'(MAX_PAYLOAD_DW);
  localparam logic [HQW:0]  HQ_FULL = (HQW+1)'(HDR_DEPTH);
  localparam logic [HQW:0]  HQ_ONE  = (HQW+1)'(1);

  typedef enum logic [1:0] {EG_IDLE, EG_HDR, EG_PAYLOAD} eg_state_t;

  logic          in_tlp;
  tlp_hdr_t      hdr_lat;
  logic [10:0]   rcv;
  tlp_hdr_t      cur_hdr;
  logic          first;
  logic          cur_has_data;
  logic [10:0]   cur_len;
  logic [10:0]   rcv_base;
  logic [11:0]   rcv_sum;
  logic [10:0]   rcv_new;
  logic          accept;
  logic          fifo_wr;
  logic          tlp_ok;
  logic          commit;
  logic          rewind;
  logic          discarding;
  logic [PW-1:0] fifo_free;
  logic [31:0]   fifo_rd_data;
  logic          fifo_rd;

  tlp_hdr_t      hq [HDR_DEPTH];
  logic [HQW:0]  hq_wr;
  logic [HQW:0]  hq_rd;
  logic [HQW:0]  hq_cnt;
  logic          hq_pop;
  tlp_hdr_t      front;
  logic          f_has_data;
  logic [2:0]    f_hdr_n;
  logic [10:0]   f_len;

  eg_state_t     eg_state, eg_next;
  logic [1:0]    hdr_idx, hdr_idx_next;
  logic [10:0]   pay_idx, pay_idx_next;
  logic          end_tlp;

  // ---------------- ingress ----------------
  assign first        = !in_tlp;
  assign cur_hdr      = first ? tlp_hdr_t'(s_tuser) : hdr_lat;
  assign cur_has_data = cur_hdr.dw0[FMT_HAS_DATA];
  assign cur_len      = tlp_len_dw(cur_hdr.dw0);
  assign rcv_base     = first ? 11'd0 : rcv;
  assign rcv_sum      = {1'b0, rcv_base} + {6'd0, keep_count(32'(s_tkeep))};
  assign rcv_new      = (rcv_sum > 12'd1025) ? 11'd1025 : rcv_sum[10:0];

  // A has-data TLP already holding MAX_DW DWs can only end in error, so its
  // remaining beats are swallowed without needing FIFO space.
  assign discarding = in_tlp && hdr_lat.dw0[FMT_HAS_DATA] && (rcv >= MAX_DW);
  assign hq_cnt     = hq_wr - hq_rd;
  assign s_tready   = (hq_cnt != HQ_FULL) && ((fifo_free >= KW_FREE) || discarding);
  assign accept     = s_tvalid && s_tready;
  assign fifo_wr    = accept && cur_has_data && (rcv_base < MAX_DW);

  assign tlp_ok = cur_has_data ? ((rcv_new == cur_len) && (cur_len <= MAX_DW)) : first;
  assign commit = accept && s_tlast && tlp_ok;
  assign rewind = accept && s_tlast && !tlp_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_tlp  <= 1'b0;
      hdr_lat <= '0;
      rcv     <= '0;
    end else if (accept) begin
      in_tlp <= !s_tlast;
      rcv    <= rcv_new;
      if (first) hdr_lat <= tlp_hdr_t'(s_tuser);
    end
  end

  tl_commit_fifo #(
    .KW    (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (s_tdata),
    .wr_keep (s_tkeep),
    .commit  (commit),
    .rewind  (rewind),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .free    (fifo_free)
  );

  // ---------------- header queue ----------------
  always_ff @(posedge clk) begin
    if (commit) hq[hq_wr[HQW-1:0]] <= cur_hdr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hq_wr <= '0;
      hq_rd <= '0;
    end else begin
      if (commit) hq_wr <= hq_wr + HQ_ONE;
      if (hq_pop) hq_rd <= hq_rd + HQ_ONE;
    end
  end

  assign front      = hq[hq_rd[HQW-1:0]];
  assign f_has_data = front.dw0[FMT_HAS_DATA];
  assign f_hdr_n    = hdr_dws(front.dw0);
  assign f_len      = tlp_len_dw(front.dw0);

  // ---------------- egress ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      eg_state  <= EG_IDLE;
      hdr_idx   <= '0;
      pay_idx   <= '0;
      tlp_count <= '0;
    end else begin
      eg_state <= eg_next;
      hdr_idx  <= hdr_idx_next;
      pay_idx  <= pay_idx_next;
      if (end_tlp) tlp_count <= tlp_count + 16'd1;
    end
  end

  // NOTE: every output of this block gets a default first so no latches form.
  always_comb begin
    eg_next      = eg_state;
    hdr_idx_next = hdr_idx;
    pay_idx_next = pay_idx;
    m_tvalid     = 1'b0;
    m_tdata      = '0;
    m_tsop       = 1'b0;
    m_teop       = 1'b0;
    fifo_rd      = 1'b0;
    hq_pop       = 1'b0;
    end_tlp      = 1'b0;
    unique case (eg_state)
      EG_IDLE: begin
        if (hq_cnt != '0) begin
          eg_next      = EG_HDR;
          hdr_idx_next = '0;
        end
      end
      EG_HDR: begin
        m_tvalid = 1'b1;
        case (hdr_idx)
          2'd0:    m_tdata = front.dw0;
          2'd1:    m_tdata = front.dw1;
          2'd2:    m_tdata = front.dw2;
          default: m_tdata = front.dw3;
        endcase
        m_tsop = (hdr_idx == 2'd0);
        m_teop = !f_has_data && ({1'b0, hdr_idx} == f_hdr_n - 3'd1);
        if (m_tready) begin
          if ({1'b0, hdr_idx} == f_hdr_n - 3'd1) begin
            if (f_has_data) begin
              eg_next      = EG_PAYLOAD;
              pay_idx_next = '0;
            end else begin
              end_tlp = 1'b1;
            end
          end else begin
            hdr_idx_next = hdr_idx + 2'd1;
          end
        end
      end
      EG_PAYLOAD: begin
        m_tvalid = 1'b1;
        m_tdata  = fifo_rd_data;
        m_teop   = (pay_idx == f_len - 11'd1);
        if (m_tready) begin
          fifo_rd = 1'b1;
          if (pay_idx == f_len - 11'd1) end_tlp = 1'b1;
          else                          pay_idx_next = pay_idx + 11'd1;
        end
      end
      default: eg_next = EG_IDLE;
    endcase
    // A header committed this cycle or already queued behind the current one
    // lets the next TLP start without an idle bubble.
    if (end_tlp) begin
      hq_pop       = 1'b1;
      hdr_idx_next = '0;
      eg_next      = ((hq_cnt != HQ_ONE) || commit) ? EG_HDR : EG_IDLE;
    end
  end

  // ---------------- error reporting ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_len   <= 1'b0;
      err_count <= '0;
    end else begin
      err_len <= rewind;
      if (rewind && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tl_tx_tlp_framer.sv
// Directed and randomized bench for tl_tx_tlp_framer against a TLP-level
// reference model (expected DW stream, drop and send counts).
module tb_tl_tx_tlp_framer;

  localparam int DATA_W     = 128;
  localparam int FIFO_DEPTH = 16;
  localparam int HDR_DEPTH  = 4;
  localparam int MAX_PL     = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [127:0] s_tuser;
  logic [127:0] s_tdata;
  logic [3:0]   s_tkeep;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tsop;
  logic         m_teop;
  logic         err_len;
  logic [15:0]  err_count;
  logic [15:0]  tlp_count;

  always #5 clk = ~clk;

  tl_tx_tlp_framer #(
    .DATA_W         (DATA_W),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .HDR_DEPTH      (HDR_DEPTH),
    .MAX_PAYLOAD_DW (MAX_PL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .s_tuser   (s_tuser),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tsop    (m_tsop),
    .m_teop    (m_teop),
    .err_len   (err_len),
    .err_count (err_count),
    .tlp_count (tlp_count)
  );

  int checks   = 0;
  int failures = 0;

  // Words are {sop, eop, data}.
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  int exp_tlp    = 0;
  int exp_err    = 0;
  int err_pulses = 0;
  int cyc        = 0;
  int sop_cyc    = 0;
  int last_span  = 0;
  bit rdy_rand   = 1'b0;
  bit rdy_fixed  = 1'b1;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Link-side monitor: captures handshaken DWs and checks hold-while-stalled.
  bit          stalled = 1'b0;
  logic [33:0] stall_word;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {m_tvalid, m_tsop, m_teop, m_tdata}, {1'b1, stall_word});
      if (m_tvalid && m_tready) begin
        obs_q.push_back({m_tsop, m_teop, m_tdata});
        if (m_tsop) sop_cyc = cyc;
        if (m_teop) last_span = cyc - sop_cyc + 1;
      end
      stalled    = m_tvalid && !m_tready;
      stall_word = {m_tsop, m_teop, m_tdata};
      if (err_len) err_pulses++;
    end
  end

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  task automatic drive_beat(input logic [127:0] user, input logic [127:0] data,
                            input logic [3:0] keep, input bit last);
    bit took;
    int waited;
    took     = 1'b0;
    waited   = 0;
    s_tvalid = 1'b1;
    s_tuser  = user;
    s_tdata  = data;
    s_tkeep  = keep;
    s_tlast  = last;
    while (!took && waited < 3000) begin
      @(negedge clk);
      took = s_tready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!took) check("tready_timeout", 64'(s_tready), 64'd1);
  endtask

  // Sends one TLP and records what the link must show for it.
  task automatic send_tlp(input logic [127:0] hdr, input int ndw, input int nd_beats,
                          input bit rand_split, input logic [31:0] base);
    logic [31:0]  dw0;
    logic [31:0]  pay[$];
    logic [127:0] data;
    logic [3:0]   keep;
    bit has, ok;
    int len, nh, idx, k;
    dw0 = hdr[31:0];
    has = dw0[30];
    len = (dw0[9:0] == 10'd0) ? 1024 : int'(dw0[9:0]);
    nh  = dw0[29] ? 4 : 3;
    @(posedge clk);
    #1;
    if (has) begin
      for (int i = 0; i < ndw; i++) pay.push_back((base != 0) ? base + 32'(i) : $urandom);
      idx = 0;
      while (idx < ndw) begin
        k = (ndw - idx > 4) ? 4 : ndw - idx;
        if (rand_split) k = $urandom_range(1, k);
        data = rand128();
        keep = '0;
        for (int j = 0; j < k; j++) begin
          data[j*32 +: 32] = pay[idx+j];
          keep[j] = 1'b1;
        end
        drive_beat((idx == 0) ? hdr : rand128(), data, keep, (idx + k) == ndw);
        idx += k;
      end
      ok = (ndw == len) && (len <= MAX_PL);
    end else begin
      for (int b = 0; b < nd_beats; b++)
        drive_beat((b == 0) ? hdr : rand128(), rand128(), 4'b1111 >> $urandom_range(0, 3),
                   b == nd_beats - 1);
      ok = (nd_beats == 1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (ok) begin
      for (int h = 0; h < nh; h++) exp_q.push_back({h == 0, !has && (h == nh - 1), hdr[h*32 +: 32]});
      for (int i = 0; i < ndw; i++) exp_q.push_back({1'b0, i == ndw - 1, pay[i]});
      exp_tlp++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    repeat (6) @(negedge clk);
    check({tag, "_dw_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) check({tag, "_dw"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
    check({tag, "_tlp_count"}, 64'(tlp_count), 64'(exp_tlp[15:0]));
    check({tag, "_err_count"}, 64'(err_count), 64'(exp_err[15:0]));
    check({tag, "_err_pulses"}, 64'(err_pulses), 64'(exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    check({tag, "_m_tdata"}, 64'(m_tdata), 64'd0);
    check({tag, "_m_tsop"}, 64'(m_tsop), 64'd0);
    check({tag, "_m_teop"}, 64'(m_teop), 64'd0);
    check({tag, "_err_len"}, 64'(err_len), 64'd0);
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
    check({tag, "_tlp_count"}, 64'(tlp_count), 64'd0);
    check({tag, "_s_tready"}, 64'(s_tready), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] h;
    int len, ndw, kind;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // 3DW write, single full beat.
    send_tlp({32'h0, 32'h1111_2222, 32'h3333_4444, 32'h4000_0004}, 4, 0, 1'b0, 32'hA0);
    drain("t1_mwr3");
    check("t1_span", 64'(last_span), 64'd7);

    // 4DW write over two beats; header and payload must be contiguous.
    send_tlp({32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA, 32'h6000_0006}, 6, 0, 1'b0, 32'h0);
    drain("t2_mwr4");
    check("t2_span", 64'(last_span), 64'd10);

    // Short TLP is dropped; the next one must carry only its own data.
    send_tlp({32'h0, 32'h0BAD_0001, 32'h0BAD_0002, 32'h4000_0004}, 3, 0, 1'b0, 32'hDEAD_0000);
    drain("t3_drop");
    send_tlp({32'h0, 32'h0600_0001, 32'h0600_0002, 32'h4000_0002}, 2, 0, 1'b0, 32'hC0);
    drain("t3_after_rewind");

    // No-data read: single beat valid, two beats malformed.
    send_tlp({32'h0, 32'h0123_4567, 32'h89AB_CDEF, 32'h0000_0001}, 0, 1, 1'b0, 32'h0);
    drain("t4_mrd");
    send_tlp({32'h0, 32'h0123_4567, 32'h89AB_CDEF, 32'h0000_0001}, 0, 2, 1'b0, 32'h0);
    drain("t4_mrd_2beat");
    send_tlp({32'h0, 32'h0700_0001, 32'h0700_0002, 32'h4000_0003}, 3, 0, 1'b1, 32'h0);
    drain("t4_after");

    // Four queued TLPs under random link backpressure.
    rdy_rand = 1'b1;
    for (int t = 0; t < 4; t++) begin
      h = rand128();
      h[30] = 1'b1;
      h[29] = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      h[9:0] = 10'(len);
      send_tlp(h, len, 0, 1'b1, 32'h0);
    end
    drain("t5_backpressure");

    // Random mix of valid, short/long and no-data TLPs.
    for (int t = 0; t < 12; t++) begin
      h = rand128();
      kind = $urandom_range(0, 5);
      len = $urandom_range(1, 11);
      h[29] = 1'($urandom_range(0, 1));
      h[9:0] = 10'(len);
      if (kind == 0) begin
        h[30] = 1'b0;
        send_tlp(h, 0, $urandom_range(1, 2), 1'b0, 32'h0);
      end else begin
        h[30] = 1'b1;
        ndw = (kind == 1) ? len + 1 : len;
        send_tlp(h, ndw, 0, 1'b1, 32'h0);
      end
    end
    drain("t5_random");
    rdy_rand = 1'b0;

    // Full FIFO stalls ingress while the link is blocked.
    rdy_fixed = 1'b0;
    send_tlp({32'h0, 32'h1600_0001, 32'h1600_0002, 32'h4000_0010}, 16, 0, 1'b0, 32'h0);
    @(negedge clk);
    check("t6_tready_full", 64'(s_tready), 64'd0);
    rdy_fixed = 1'b1;
    drain("t6_full");

    // Length 0 means 1024 DWs, above the maximum: dropped after swallowing it.
    send_tlp({32'h0, 32'h1024_0001, 32'h1024_0002, 32'h4000_0000}, 1024, 0, 1'b0, 32'h0);
    drain("t6_len1024");
    send_tlp({32'h0, 32'h1700_0001, 32'h1700_0002, 32'h4000_0005}, 5, 0, 1'b1, 32'h0);
    drain("t6_after");

    // Reset with one TLP queued and another half received.
    rdy_fixed = 1'b0;
    send_tlp({32'h0, 32'h1800_0001, 32'h1800_0002, 32'h4000_0004}, 4, 0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    drive_beat({96'h0, 32'h4000_0008}, rand128(), 4'b1111, 1'b0);
    drive_beat(rand128(), rand128(), 4'b1111, 1'b0);
    s_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    exp_tlp    = 0;
    exp_err    = 0;
    err_pulses = 0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rdy_fixed = 1'b1;
    send_tlp({32'h1900_0003, 32'h1900_0001, 32'h1900_0002, 32'h6000_0005}, 5, 0, 1'b1, 32'h0);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
